multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/cpu_pkg.sv | 63 ++++++
 rtl/multicycle_control.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU: opcodes, ALU operation codes,
// ALU operand-B selects, control FSM states and the control strobe bundle.
package cpu_pkg;

  localparam int unsigned OPCODE_W = 7;
  localparam int unsigned STATE_W  = 4;
  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned SRCB_W   = 2;

  localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OP_IMM    = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

  // ALU control decoder input: how the ALU operation is chosen
  typedef enum logic [ALUOP_W-1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_IMM   = 2'b11
  } alu_op_e;

  typedef enum logic [SRCB_W-1:0] {
    SRCB_REG  = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10
  } alu_srcb_e;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_HALT     = 4'd10
  } state_e;

  typedef struct packed {
    logic      pc_write;
    logic      ir_write;
    logic      ior_d;
    logic      mem_read;
    logic      mem_write;
    logic      reg_write;
    logic      memto_reg;
    logic      alu_src_a;
    logic      pc_src;
    alu_srcb_e alu_src_b;
    alu_op_e   alu_op;
    logic      illegal;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [OPCODE_W-1:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM: one state register plus a combined next-state
// and strobe decode; memory states stall on MemReady_i.
module multicycle_control
  import cpu_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [OPCODE_W-1:0] Opcode_i,
  input  logic                Zero_i,
  input  logic                MemReady_i,
  output logic                PCWrite_o,
  output logic                IRWrite_o,
  output logic                IorD_o,
  output logic                MemRead_o,
  output logic                MemWrite_o,
  output logic                RegWrite_o,
  output logic                MemtoReg_o,
  output logic                ALUSrcA_o,
  output logic                PCSrc_o,
  output logic [SRCB_W-1:0]   ALUSrcB_o,
  output logic [ALUOP_W-1:0]  ALUOp_o,
  output logic                Illegal_o,
  output logic [STATE_W-1:0]  State_o
);

  state_e state_q;
  state_e state_d;
  ctrl_t  ctrl_c;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctrl_c  = '0;
    case (state_q)
      S_FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = SRCB_FOUR;
        ctrl_c.alu_op    = ALUOP_ADD;
        ctrl_c.ir_write  = MemReady_i;
        ctrl_c.pc_write  = MemReady_i;
        if (MemReady_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        // ALU precomputes the branch target while the opcode is decoded
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALUOP_ADD;
        if (Opcode_i == OP_RTYPE) begin
          state_d = S_EXEC_R;
        end else if (Opcode_i == OP_IMM) begin
          state_d = S_EXEC_I;
        end else if (is_mem_op(Opcode_i)) begin
          state_d = S_MEM_ADDR;
        end else if (Opcode_i == OP_BRANCH) begin
          state_d = S_BRANCH;
        end else begin
          ctrl_c.illegal = 1'b1;
          state_d        = ILLEGAL_HALT ? S_HALT : S_FETCH;
        end
      end
      S_EXEC_R: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_REG;
        ctrl_c.alu_op    = ALUOP_FUNCT;
        state_d          = S_R_WB;
      end
      S_EXEC_I: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALUOP_IMM;
        state_d          = S_R_WB;
      end
      S_R_WB: begin
        ctrl_c.reg_write = 1'b1;
        state_d          = S_FETCH;
      end
      S_MEM_ADDR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALUOP_ADD;
        if (Opcode_i == OP_LOAD) begin
          state_d = S_MEM_RD;
        end else if (Opcode_i == OP_STORE) begin
          state_d = S_MEM_WR;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM_RD: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.ior_d    = 1'b1;
        if (MemReady_i) state_d = S_MEM_WB;
      end
      S_MEM_WR: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.ior_d     = 1'b1;
        if (MemReady_i) state_d = S_FETCH;
      end
      S_MEM_WB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.memto_reg = 1'b1;
        state_d          = S_FETCH;
      end
      S_BRANCH: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_REG;
        ctrl_c.alu_op    = ALUOP_SUB;
        ctrl_c.pc_src    = 1'b1;
        ctrl_c.pc_write  = Zero_i;
        state_d          = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
    // Reset silences every strobe, including a memory access in flight
    if (rst_i) ctrl_c = '0;
  end

  assign PCWrite_o  = ctrl_c.pc_write;
  assign IRWrite_o  = ctrl_c.ir_write;
  assign IorD_o     = ctrl_c.ior_d;
  assign MemRead_o  = ctrl_c.mem_read;
  assign MemWrite_o = ctrl_c.mem_write;
  assign RegWrite_o = ctrl_c.reg_write;
  assign MemtoReg_o = ctrl_c.memto_reg;
  assign ALUSrcA_o  = ctrl_c.alu_src_a;
  assign PCSrc_o    = ctrl_c.pc_src;
  assign ALUSrcB_o  = ctrl_c.alu_src_b;
  assign ALUOp_o    = ctrl_c.alu_op;
  assign Illegal_o  = ctrl_c.illegal;
  assign State_o    = state_q;

endmodule
